// File: rtl/axi_wr_slave_mem.sv
// AXI3 write-path slave: one burst at a time into a word memory, B response per burst, debug read port.
// Optional AXI_WR_SLV_PROTO_CHECK_EN: honour wlast and check wid against awid.
module axi_wr_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         aclk,
    input  logic                         arst,
    input  logic [3:0]                   awid,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [7:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [3:0]                   wid,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [3:0]                   bid,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_idx,
    output logic [DATA_WIDTH-1:0]        dbg_rdata
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LOG2B = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_e;

    state_e                  state_q, state_d;
    logic                    awready_q, wready_q, bvalid_q;
    logic [3:0]              bid_q, bid_d, id_q, id_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d, beat_q, beat_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic                    aw_err_q, aw_err_d, proto_err_q, proto_err_d, dec_err_q, dec_err_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]   inc, span, wrap_addr, next_addr, aw_mask;
    logic                    beat_fire, beat_oob, last_by_len, beat_last, beat_proto_err, wid_bad;
    logic                    aw_err, mem_we;
    logic [IDXW-1:0]         widx;

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bid       = bid_q;
    assign bresp     = bresp_q;
    assign dbg_rdata = mem_q[dbg_idx];

    assign inc         = ADDR_WIDTH'(1) << size_q;
    assign span        = ADDR_WIDTH'({1'b0, len_q} + 9'd1) << size_q;
    assign wrap_addr   = (addr_q & ~(span - ADDR_WIDTH'(1))) | ((addr_q + inc) & (span - ADDR_WIDTH'(1)));
    assign next_addr   = (burst_q == 2'b00) ? addr_q : (burst_q == 2'b10) ? wrap_addr : addr_q + inc;
    assign beat_fire   = wvalid & wready_q;
    assign beat_oob    = {1'b0, addr_q} >= MEM_BYTES;
    assign last_by_len = (beat_q == len_q);
    assign widx        = addr_q[LOG2B +: IDXW];

`ifdef AXI_WR_SLV_PROTO_CHECK_EN
    assign wid_bad        = (wid != id_q);
    assign beat_last      = last_by_len | wlast;
    assign beat_proto_err = (wlast != last_by_len) | wid_bad;
`else
    logic unused_proto;
    assign unused_proto   = ^{wid, wlast};
    assign wid_bad        = 1'b0;
    assign beat_last      = last_by_len;
    assign beat_proto_err = 1'b0;
`endif

    // Attribute errors are decided once at AW accept and suppress every write of the burst.
    assign aw_mask = (ADDR_WIDTH'(1) << awsize) - ADDR_WIDTH'(1);
    assign aw_err  = (awburst == 2'b11)
                   | (awsize > 3'(LOG2B))
                   | ((awburst == 2'b10) & ~((awlen == 8'd1) | (awlen == 8'd3) |
                                             (awlen == 8'd7) | (awlen == 8'd15)))
                   | ((awburst == 2'b10) & (|(awaddr & aw_mask)));
    assign mem_we  = beat_fire & ~aw_err_q & ~beat_oob & ~wid_bad;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        aw_err_d    = aw_err_q;
        proto_err_d = proto_err_q;
        dec_err_d   = dec_err_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        case (state_q)
            S_IDLE: begin
                if (awvalid && awready_q) begin
                    id_d        = awid;
                    addr_d      = awaddr;
                    len_d       = awlen;
                    size_d      = awsize;
                    burst_d     = awburst;
                    beat_d      = 8'd0;
                    aw_err_d    = aw_err;
                    proto_err_d = 1'b0;
                    dec_err_d   = 1'b0;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (beat_fire) begin
                    beat_d      = beat_q + 8'd1;
                    addr_d      = next_addr;
                    dec_err_d   = dec_err_q | beat_oob;
                    proto_err_d = proto_err_q | beat_proto_err;
                    if (beat_last) begin
                        state_d = S_RESP;
                        bid_d   = id_q;
                        bresp_d = (dec_err_q | beat_oob) ? 2'b11 :
                                  (aw_err_q | proto_err_q | beat_proto_err) ? 2'b10 : 2'b00;
                    end
                end
            end
            S_RESP: begin
                if (bvalid_q && bready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= 4'd0;
            bresp_q     <= 2'b00;
            id_q        <= 4'd0;
            addr_q      <= '0;
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= 2'b00;
            beat_q      <= 8'd0;
            aw_err_q    <= 1'b0;
            proto_err_q <= 1'b0;
            dec_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            awready_q   <= (state_d == S_IDLE);
            wready_q    <= (state_d == S_DATA);
            bvalid_q    <= (state_d == S_RESP);
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            aw_err_q    <= aw_err_d;
            proto_err_q <= proto_err_d;
            dec_err_q   <= dec_err_d;
        end
    end

    // Memory has no reset so an aborted burst leaves its completed beats in place.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Directed bench for axi_wr_slave_mem (DATA_WIDTH=32, MEM_DEPTH=256).
module tb_axi_wr_slave_mem;
    logic        aclk = 1'b0;
    logic        arst;
    logic [3:0]  awid, wid, bid;
    logic [31:0] awaddr, wdata, dbg_rdata;
    logic [7:0]  awlen, dbg_idx;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_run  = 0;
    int n_fail = 0;

    axi_wr_slave_mem dut (
        .aclk(aclk), .arst(arst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_idx(dbg_idx), .dbg_rdata(dbg_rdata)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        @(posedge aclk); #1;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 20) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("aw_ready", 32'(awready), 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                          input logic last);
        int n;
        wid = id; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        n = 0;
        while (wready !== 1'b1 && n < 20) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("w_ready", 32'(wready), 32'd1);
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_wait(input logic [3:0] id, input logic [1:0] resp);
        int n;
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("bvalid", 32'(bvalid), 32'd1);
        chk("bid", 32'(bid), 32'(id));
        chk("bresp", 32'(bresp), 32'(resp));
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        chk("idle_awready", 32'(awready), 32'd1);
        chk("idle_wready", 32'(wready), 32'd0);
    endtask

    task automatic mem_chk(input logic [7:0] idx, input logic [31:0] exp);
        @(negedge aclk);
        dbg_idx = idx;
        #1;
        chk($sformatf("mem%0d", idx), dbg_rdata, exp);
    endtask

    initial begin
        arst = 1'b1; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        wid = '0; wdata = '0; wstrb = '0; dbg_idx = '0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_bid", 32'(bid), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        arst = 1'b0;
        #1;
        chk("pre_awready", 32'(awready), 32'd0);
        @(posedge aclk); #1;
        chk("post_awready", 32'(awready), 32'd1);

        // INCR at 0x10, four beats -> words 4..7
        aw_send(4'd5, 32'h10, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) w_beat(4'd5, 32'hA0 + 32'(i), 4'hF, i == 3);
        b_wait(4'd5, 2'b00);
        for (int i = 0; i < 4; i++) mem_chk(8'(4 + i), 32'hA0 + 32'(i));

        // WRAP at 0x38 over a 16-byte span -> words 14,15,12,13
        aw_send(4'd2, 32'h38, 8'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++) w_beat(4'd2, 32'hB0 + 32'(i), 4'hF, i == 3);
        b_wait(4'd2, 2'b00);
        mem_chk(8'd14, 32'hB0);
        mem_chk(8'd15, 32'hB1);
        mem_chk(8'd12, 32'hB2);
        mem_chk(8'd13, 32'hB3);

        // FIXED with partial strobes merges both beats into word 8
        aw_send(4'd1, 32'h20, 8'd1, 3'd2, 2'b00);
        w_beat(4'd1, 32'h1111_2222, 4'h3, 1'b0);
        w_beat(4'd1, 32'h3333_4444, 4'hC, 1'b1);
        b_wait(4'd1, 2'b00);
        mem_chk(8'd8, 32'h3333_2222);

        // Seed word 16, then a reserved-burst write must leave it alone
        aw_send(4'd0, 32'h40, 8'd0, 3'd2, 2'b01);
        w_beat(4'd0, 32'hDEAD_BEEF, 4'hF, 1'b1);
        b_wait(4'd0, 2'b00);
        aw_send(4'd3, 32'h40, 8'd1, 3'd2, 2'b11);
        w_beat(4'd3, 32'h1234_5678, 4'hF, 1'b0);
        w_beat(4'd3, 32'h1234_5678, 4'hF, 1'b1);
        repeat (5) begin
            @(posedge aclk); #1;
            chk("hold_bvalid", 32'(bvalid), 32'd1);
            chk("hold_bid", 32'(bid), 32'd3);
            chk("hold_bresp", 32'(bresp), 32'd2);
        end
        b_wait(4'd3, 2'b10);
        mem_chk(8'd16, 32'hDEAD_BEEF);

        // Oversized beat and illegal wrap length both give SLVERR
        aw_send(4'd6, 32'h40, 8'd0, 3'd3, 2'b01);
        w_beat(4'd6, 32'h0, 4'hF, 1'b1);
        b_wait(4'd6, 2'b10);
        aw_send(4'd7, 32'h40, 8'd2, 3'd2, 2'b10);
        for (int i = 0; i < 3; i++) w_beat(4'd7, 32'h0, 4'hF, i == 2);
        b_wait(4'd7, 2'b10);
        mem_chk(8'd16, 32'hDEAD_BEEF);

        // Reset mid-burst after two beats
        aw_send(4'd9, 32'h0, 8'd7, 3'd2, 2'b01);
        w_beat(4'd9, 32'hC0, 4'hF, 1'b0);
        w_beat(4'd9, 32'hC1, 4'hF, 1'b0);
        arst = 1'b1;
        #1;
        chk("mid_rst_wready", 32'(wready), 32'd0);
        chk("mid_rst_awready", 32'(awready), 32'd0);
        chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
        @(posedge aclk); #1;
        arst = 1'b0;
        @(posedge aclk); #1;
        chk("rec_awready", 32'(awready), 32'd1);
        mem_chk(8'd0, 32'hC0);
        mem_chk(8'd1, 32'hC1);

        // Out of range address -> DECERR, aliasing word 0 untouched
        aw_send(4'd4, 32'h400, 8'd1, 3'd2, 2'b01);
        w_beat(4'd4, 32'h5555_5555, 4'hF, 1'b0);
        w_beat(4'd4, 32'h5555_5555, 4'hF, 1'b1);
        b_wait(4'd4, 2'b11);
        mem_chk(8'd0, 32'hC0);

        aw_send(4'd8, 32'h8, 8'd0, 3'd2, 2'b01);
        w_beat(4'd8, 32'hC2, 4'hF, 1'b1);
        b_wait(4'd8, 2'b00);
        mem_chk(8'd2, 32'hC2);

`ifdef AXI_WR_SLV_PROTO_CHECK_EN
        aw_send(4'd4, 32'h50, 8'd3, 3'd2, 2'b01);
        w_beat(4'd4, 32'hD0, 4'hF, 1'b0);
        w_beat(4'd4, 32'hD1, 4'hF, 1'b1);
        b_wait(4'd4, 2'b10);
        mem_chk(8'd21, 32'hD1);
        aw_send(4'd4, 32'h8, 8'd0, 3'd2, 2'b01);
        w_beat(4'd5, 32'hEE, 4'hF, 1'b1);
        b_wait(4'd4, 2'b10);
        mem_chk(8'd2, 32'hC2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
